// File: rtl/matrix_pkg.sv
// Shared constants for the LED matrix path: geometry defaults and FSM state codes.
// The downstream scanner imports the same package so both sides agree on size.
package matrix_pkg;

  localparam int DEFAULT_ROWS = 8;
  localparam int DEFAULT_COLS = 8;

  localparam logic [1:0] ST_IDLE      = 2'd0;
  localparam logic [1:0] ST_CLEAR     = 2'd1;
  localparam logic [1:0] ST_WAIT_SWAP = 2'd2;

  // Index width that stays legal for a degenerate one-row matrix.
  function automatic int row_bits(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/matrix_frame_buffer_if.sv
// Write/control/display bundle of the matrix frame buffer.
// Handshake: a row write transfers on a rising edge where wr_valid && wr_ready are both high.
interface matrix_frame_buffer_if
  import matrix_pkg::*;
#(
  parameter int ROWS = DEFAULT_ROWS,
  parameter int COLS = DEFAULT_COLS
);

  logic                     wr_valid;
  logic                     wr_ready;
  logic [row_bits(ROWS)-1:0] wr_row;
  logic [COLS-1:0]          wr_data;
  logic                     commit;
  logic                     clear;
  logic                     frame_sync;
  logic [ROWS*COLS-1:0]     led_data;
  logic                     swap_pending;
  logic                     swap_done;
  logic [1:0]               state_dbg;

  modport master (
    output wr_valid, wr_row, wr_data, commit, clear, frame_sync,
    input  wr_ready, led_data, swap_pending, swap_done, state_dbg
  );

  modport slave (
    input  wr_valid, wr_row, wr_data, commit, clear, frame_sync,
    output wr_ready, led_data, swap_pending, swap_done, state_dbg
  );

endinterface

// File: rtl/matrix_frame_buffer.sv
// Double-buffered LED matrix store: rows are written into a back buffer and the
// whole frame is copied to the displayed front buffer on the frame boundary after a commit.
module matrix_frame_buffer
  import matrix_pkg::*;
#(
  parameter int ROWS = DEFAULT_ROWS,
  parameter int COLS = DEFAULT_COLS
) (
  input logic                  sys_clock,
  input logic                  sys_reset,
  matrix_frame_buffer_if.slave bus
);

  localparam int RW = row_bits(ROWS);

  logic [1:0]           state;
  logic [RW-1:0]        clr_row;
  logic [COLS-1:0]      back [ROWS];
  logic [ROWS*COLS-1:0] front;
  logic                 swap_done_q;

  logic wr_fire;
  logic row_ok;
  logic do_swap;

  assign bus.wr_ready     = (state == ST_IDLE) && !bus.clear;
  assign wr_fire          = bus.wr_valid && bus.wr_ready;
  assign row_ok           = (int'(bus.wr_row) < ROWS);
  assign do_swap          = (state == ST_WAIT_SWAP) && bus.frame_sync;

  assign bus.led_data     = front;
  assign bus.swap_pending = (state == ST_WAIT_SWAP);
  assign bus.swap_done    = swap_done_q;
  assign bus.state_dbg    = state;

  // Control FSM. A commit never arrives while a frame_sync can act on it in the
  // same edge, because the swap is only examined once the state is WAIT_SWAP.
  always_ff @(posedge sys_clock or posedge sys_reset) begin
    if (sys_reset) begin
      state   <= ST_IDLE;
      clr_row <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.clear) begin
            state   <= ST_CLEAR;
            clr_row <= '0;
          end else if (bus.commit) begin
            state <= ST_WAIT_SWAP;
          end
        end
        ST_CLEAR: begin
          if (clr_row == RW'(ROWS - 1)) begin
            state   <= ST_IDLE;
            clr_row <= '0;
          end else begin
            clr_row <= clr_row + 1'b1;
          end
        end
        ST_WAIT_SWAP: begin
          if (bus.frame_sync) begin
            state <= ST_IDLE;
          end
        end
        default: begin
          state   <= ST_IDLE;
          clr_row <= '0;
        end
      endcase
    end
  end

  // Back buffer: handshaked writes and the row-by-row clear never overlap,
  // since wr_ready is low throughout CLEAR. Out-of-range rows are dropped.
  always_ff @(posedge sys_clock or posedge sys_reset) begin
    if (sys_reset) begin
      for (int r = 0; r < ROWS; r++) begin
        back[r] <= '0;
      end
    end else if (wr_fire) begin
      if (row_ok) begin
        back[bus.wr_row] <= bus.wr_data;
      end
    end else if (state == ST_CLEAR) begin
      back[clr_row] <= '0;
    end
  end

  // Front buffer changes only here, all rows in one edge, so the display never
  // sees a partially updated frame.
  always_ff @(posedge sys_clock or posedge sys_reset) begin
    if (sys_reset) begin
      front       <= '0;
      swap_done_q <= 1'b0;
    end else begin
      swap_done_q <= do_swap;
      if (do_swap) begin
        for (int r = 0; r < ROWS; r++) begin
          front[r*COLS +: COLS] <= back[r];
        end
      end
    end
  end

endmodule

// File: tb/tb_matrix_frame_buffer.sv
// Directed bench for matrix_frame_buffer; swap results are checked by a
// negedge monitor against an expected-frame queue.
module tb_matrix_frame_buffer;
  import matrix_pkg::*;

  localparam int ROWS = 8;
  localparam int COLS = 8;
  localparam int W    = ROWS * COLS;

  logic sys_clock;
  logic sys_reset;

  matrix_frame_buffer_if #(.ROWS(ROWS), .COLS(COLS)) bus ();

  matrix_frame_buffer #(.ROWS(ROWS), .COLS(COLS)) dut (
    .sys_clock (sys_clock),
    .sys_reset (sys_reset),
    .bus       (bus)
  );

  // clock / reset
  initial sys_clock = 1'b0;
  always #5 sys_clock = ~sys_clock;

  int n_pass  = 0;
  int n_total = 0;
  logic [W-1:0] exp_q[$];

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // scoreboard monitor: every swap_done must match a queued frame
  always @(negedge sys_clock) begin
    if (!sys_reset && bus.swap_done === 1'b1) begin
      if (exp_q.size() == 0) check("swap_done_unexpected", W'(bus.swap_done), W'(0));
      else check("swap_frame", bus.led_data, exp_q.pop_front());
    end
  end

  // driver tasks
  task automatic cycle();
    @(posedge sys_clock);
    #1;
  endtask

  task automatic write_row(input logic [2:0] row, input logic [7:0] data);
    bus.wr_valid = 1'b1;
    bus.wr_row   = row;
    bus.wr_data  = data;
    check("wr_ready_on_write", W'(bus.wr_ready), W'(1));
    cycle();
    bus.wr_valid = 1'b0;
  endtask

  task automatic pulse_commit();
    bus.commit = 1'b1;
    cycle();
    bus.commit = 1'b0;
  endtask

  task automatic pulse_sync();
    bus.frame_sync = 1'b1;
    cycle();
    bus.frame_sync = 1'b0;
  endtask

  initial begin
    sys_reset      = 1'b1;
    bus.wr_valid   = 1'b0;
    bus.wr_row     = '0;
    bus.wr_data    = '0;
    bus.commit     = 1'b0;
    bus.clear      = 1'b0;
    bus.frame_sync = 1'b0;
    #2;
    check("reset_async_led", bus.led_data, '0);
    repeat (3) cycle();
    sys_reset = 1'b0;
    cycle();
    check("reset_led", bus.led_data, '0);
    check("reset_wr_ready", W'(bus.wr_ready), W'(1));
    check("reset_pending", W'(bus.swap_pending), W'(0));
    check("reset_state", W'(bus.state_dbg), W'(ST_IDLE));

    // write, commit, sync five cycles later
    write_row(3'd0, 8'hA5);
    write_row(3'd7, 8'h3C);
    pulse_commit();
    check("commit_pending", W'(bus.swap_pending), W'(1));
    repeat (4) cycle();
    check("led_before_swap", bus.led_data, '0);
    exp_q.push_back(64'h3C00_0000_0000_00A5);
    pulse_sync();
    check("swap_done_high", W'(bus.swap_done), W'(1));
    check("led_row0", W'(bus.led_data[7:0]), W'(8'hA5));
    check("led_row7", W'(bus.led_data[63:56]), W'(8'h3C));
    check("pending_cleared", W'(bus.swap_pending), W'(0));
    cycle();
    check("swap_done_one_cycle", W'(bus.swap_done), W'(0));

    // write attempted while waiting for the swap
    pulse_commit();
    bus.wr_valid = 1'b1;
    bus.wr_row   = 3'd2;
    bus.wr_data  = 8'hFF;
    #1;
    check("wait_wr_ready", W'(bus.wr_ready), W'(0));
    cycle();
    bus.wr_valid = 1'b0;
    exp_q.push_back(64'h3C00_0000_0000_00A5);
    cycle();
    pulse_sync();
    check("wait_row2_unchanged", W'(bus.led_data[23:16]), W'(8'h00));
    cycle();

    // load all ones, then clear (a commit during CLEAR is ignored)
    for (int r = 0; r < ROWS; r++) write_row(3'(r), 8'hFF);
    bus.clear = 1'b1;
    #1;
    check("clear_pulse_wr_ready", W'(bus.wr_ready), W'(0));
    cycle();
    bus.clear = 1'b0;
    for (int i = 0; i < ROWS; i++) begin
      check($sformatf("clear_wr_ready_%0d", i), W'(bus.wr_ready), W'(0));
      bus.commit = (i == 3);
      cycle();
      bus.commit = 1'b0;
    end
    check("clear_done_wr_ready", W'(bus.wr_ready), W'(1));
    check("clear_commit_ignored", W'(bus.swap_pending), W'(0));
    pulse_commit();
    exp_q.push_back('0);
    pulse_sync();
    check("clear_led_zero", bus.led_data, '0);
    cycle();

    // write + commit + frame_sync in one cycle: no swap until the next sync
    bus.wr_valid   = 1'b1;
    bus.wr_row     = 3'd1;
    bus.wr_data    = 8'h11;
    bus.commit     = 1'b1;
    bus.frame_sync = 1'b1;
    cycle();
    bus.wr_valid   = 1'b0;
    bus.commit     = 1'b0;
    bus.frame_sync = 1'b0;
    check("simul_pending", W'(bus.swap_pending), W'(1));
    check("simul_no_swap_done", W'(bus.swap_done), W'(0));
    check("simul_led_unchanged", bus.led_data, '0);
    cycle();
    exp_q.push_back(64'h0000_0000_0000_1100);
    pulse_sync();
    check("simul_row1", W'(bus.led_data[15:8]), W'(8'h11));
    cycle();

    // frame_sync in IDLE does nothing
    write_row(3'd4, 8'h5A);
    pulse_sync();
    check("idle_sync_no_done", W'(bus.swap_done), W'(0));
    check("idle_sync_led", bus.led_data, 64'h0000_0000_0000_1100);

    // reset during WAIT_SWAP abandons the swap
    pulse_commit();
    check("rst_wait_pending", W'(bus.swap_pending), W'(1));
    sys_reset = 1'b1;
    #2;
    check("rst_async_led", bus.led_data, '0);
    check("rst_async_pending", W'(bus.swap_pending), W'(0));
    bus.frame_sync = 1'b1;
    cycle();
    sys_reset = 1'b0;
    cycle();
    bus.frame_sync = 1'b0;
    check("rst_led_stays_zero", bus.led_data, '0);
    check("rst_no_swap_done", W'(bus.swap_done), W'(0));
    check("rst_wr_ready", W'(bus.wr_ready), W'(1));
    repeat (3) cycle();
    check("queue_drained", W'(exp_q.size()), W'(0));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/matrix_frame_buffer.md
MATRIX_FRAME_BUFFER -- requirements
Module: matrix_frame_buffer

Interface
REQ-001 The block SHALL have parameter ROWS, default 8, the number of matrix rows.
REQ-002 The block SHALL have parameter COLS, default 8, the number of columns per row.
REQ-003 sys_clock  input  1  the single clock; all state changes on its rising edge.
REQ-004 sys_reset  input  1  reset, asynchronous, active-high.
REQ-005 wr_valid  input  1  a row write is offered.
REQ-006 wr_ready  output  1  a row write can be accepted this cycle.
REQ-007 wr_row  input  $clog2(ROWS)  index of the back-buffer row to write.
REQ-008 wr_data  input  COLS  column pattern for that row; bit c drives column c.
REQ-009 commit  input  1  single-cycle pulse requesting that the back buffer be displayed.
REQ-010 clear  input  1  single-cycle pulse requesting that the back buffer be zeroed.
REQ-011 frame_sync  input  1  single-cycle pulse from the downstream scanner, marking a frame boundary (row wrap to 0).
REQ-012 led_data  output  ROWS*COLS  front buffer, registered; row r occupies bits [r*COLS +: COLS].
REQ-013 swap_pending  output  1  high while a commit is waiting for frame_sync.
REQ-014 swap_done  output  1  one-cycle pulse, high in the cycle after the swap.

Function
REQ-015 The block SHALL hold a back buffer and a front buffer, each ROWS x COLS bits; only the front buffer drives led_data.
REQ-016 The block SHALL implement states IDLE, CLEAR and WAIT_SWAP.
REQ-017 wr_ready SHALL equal (state==IDLE && !clear).
REQ-018 A write SHALL occur when wr_valid && wr_ready are high; back[wr_row] takes wr_data at that edge.
REQ-019 A handshaked write with wr_row >= ROWS SHALL be consumed and discarded, leaving the buffers unchanged.
REQ-020 In IDLE, a clear pulse SHALL move the state to CLEAR and reset the row counter to 0; a commit in the same cycle is ignored.
REQ-021 In CLEAR, the block SHALL zero one back row per cycle (rows 0..ROWS-1) and then return to IDLE, so CLEAR lasts exactly ROWS cycles.
REQ-022 In CLEAR, commit and clear pulses SHALL be ignored.
REQ-023 In IDLE, a commit pulse (with clear low) SHALL move the state to WAIT_SWAP; a handshaked write in the same cycle is applied and is included in the committed frame.
REQ-024 A frame_sync in the same cycle as the accepted commit SHALL NOT trigger the swap; the block waits for the next frame_sync.
REQ-025 In WAIT_SWAP, at the edge where frame_sync is high, the block SHALL copy the whole back buffer into the front buffer and return to IDLE; the back buffer keeps its contents.
REQ-026 led_data SHALL change only at a swap edge or at reset; it never shows a partially written frame.
REQ-027 swap_pending SHALL be high exactly while state==WAIT_SWAP.
REQ-028 swap_done SHALL pulse for one cycle, asserted by the same edge that updates led_data.
REQ-029 In WAIT_SWAP, commit and clear pulses SHALL be ignored.
REQ-030 frame_sync in IDLE or CLEAR SHALL have no effect.

Reset
REQ-031 On sys_reset high, with no clock required, the block SHALL set state=IDLE, row counter=0, both buffers all-zero, led_data=0, swap_pending=0 and swap_done=0.
REQ-032 A reset asserted mid-CLEAR or mid-WAIT_SWAP SHALL abandon the operation; no swap occurs and no swap_done pulse follows.
REQ-033 The block SHALL leave reset on the first clock edge after sys_reset falls, in IDLE with wr_ready=1.

Structure
REQ-034 A shared package matrix_pkg SHALL hold the state enumeration (IDLE, CLEAR, WAIT_SWAP) and the default ROWS/COLS constants; the downstream scanner uses the same constants.
REQ-035 The block SHALL be a single module with no sub-modules; the back buffer is a register array, not an inferred RAM, because all rows are copied in one cycle.

Verification
REQ-036 The bench SHALL check reset: after reset, led_data=0, wr_ready=1, swap_pending=0.
REQ-037 The bench SHALL check write, commit and sync: write row0=8'hA5 and row7=8'h3C, commit, then frame_sync 5 cycles later -> led_data[7:0]=A5, led_data[63:56]=3C, with swap_done high for exactly one cycle at that edge.
REQ-038 The bench SHALL check write during the wait: in WAIT_SWAP, wr_valid with row2=8'hFF -> wr_ready=0, nothing written, and led_data row2 unchanged after the swap.
REQ-039 The bench SHALL check clear: clear after loading all rows=8'hFF -> wr_ready=0 for 8 cycles, then a commit and frame_sync -> led_data=0.
REQ-040 The bench SHALL check simultaneous events: commit and frame_sync in the same cycle -> no swap; the next frame_sync swaps. Write and commit in the same cycle -> the written row appears after the swap.
REQ-041 The bench SHALL check reset during WAIT_SWAP: assert reset, then frame_sync -> led_data stays 0 and no swap_done pulse occurs.
